regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Write-side initiator for the 8x16 register file. Drives its RD / WriteData / RegWrite write port.
- Accepts writeback requests from the ALU and load paths into a small in-order FIFO, then issues at most one register-file write per cycle.
- Provides forwarding lookups on RS/RT, so decode sees values that are queued but not yet written.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register index width (8 registers)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
AluValid  input  1  ALU writeback request
AluRD  input  ADDR_W  ALU destination register
AluData  input  DATA_W  ALU result
AluReady  output  1  ALU request accepted this cycle
MemValid  input  1  load writeback request
MemRD  input  ADDR_W  load destination register
MemData  input  DATA_W  load data
MemReady  output  1  load request accepted this cycle
RD  output  ADDR_W  register-file write address
WriteData  output  DATA_W  register-file write data
RegWrite  output  1  register-file write enable
LookupRS  input  ADDR_W  forwarding query A
LookupRT  input  ADDR_W  forwarding query B
FwdRSHit  output  1  pending write to LookupRS exists
FwdRSData  output  DATA_W  youngest pending data for LookupRS (0 if no hit)
FwdRTHit  output  1  pending write to LookupRT exists
FwdRTData  output  DATA_W  youngest pending data for LookupRT (0 if no hit)
Count  output  $clog2(DEPTH+1)  occupied FIFO entries
Full  output  1  Count==DEPTH
Empty  output  1  Count==0

Behaviour:
- Reset (Reset_n low, asynchronous): Count=0, read/write pointers=0, RegWrite=0, RD=0, WriteData=0. All queued entries are dropped, including an entry held in the output stage. No write is issued on the first edge after release.
- Enqueue (combinational ready, registered storage):
  - At most one enqueue per cycle. Mem has priority over Alu.
  - MemReady = !Full.
  - AluReady = !Full && !MemValid.
  - A transfer occurs on the rising edge when Valid && Ready. The entry stores {RD, Data}.
- Dequeue and output stage:
  - On each rising edge, if Count>0 (evaluated before that edge's enqueue), pop the head into the RD/WriteData outputs and set RegWrite=1. Otherwise RegWrite=0; RD and WriteData hold their values.
  - Latency: a request accepted at edge N drives RegWrite=1 after edge N+1. The register file captures it at edge N+2.
  - An entry enqueued into an empty FIFO cannot pop on the same edge; there is no bypass.
  - Drain rate is 1 per cycle, so sustained 1 request/cycle never fills the FIFO.
- Simultaneous enqueue and dequeue: Count is unchanged and the pointers both advance, modulo DEPTH (wrap-around).
- Full with dequeue pending: ready stays 0 that cycle. Ready is based on current Count only, with no full-bypass.
- Forwarding (combinational):
  - Search all valid FIFO entries plus the output stage when RegWrite=1. The output stage counts because the register file has not yet captured it this cycle.
  - Priority is youngest first: tail-1 down to head, then the output stage.
  - Hit=0 and Data=0 when nothing matches.
  - Requests being enqueued this cycle are not searched.
- Ordering: writes reach the register file strictly in acceptance order. For the same RD, the later write wins.
- Register 0 has no special treatment; it is writable.
- Count width arithmetic is unsigned. Pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset then idle → RegWrite=0, Count=0, Empty=1, FwdRSHit=0 for 20 cycles.
- AluValid with AluRD=3, AluData=16'h1234 for one cycle → Count=1 after edge 1; RegWrite=1, RD=3, WriteData=16'h1234 after edge 2; RegWrite=0 after edge 3.
- AluValid and MemValid both high (Alu RD=1 16'hAAAA, Mem RD=2 16'h5555) → MemReady=1, AluReady=0; the Mem entry is written first and the Alu entry follows on the next cycle.
- Stall the drain by pulsing Reset_n low for 1 cycle mid-burst, after queueing 4 entries → Count=0 and RegWrite=0 immediately (asynchronous); no queued write is issued after release.
- Queue RD=5 16'h0001 then RD=5 16'h0002, with LookupRS=5 held → FwdRSData=16'h0002 while both are pending; 16'h0002 after the first one writes; Hit=0 once the second one writes.
- Back-to-back Mem requests for 10 cycles with RD cycling 0..7 → Count never exceeds 1; writes issue in order; pointers wrap past DEPTH correctly.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// Writeback queue for the 8x16 register file. It accepts ALU and load
// writebacks into an in-order FIFO and issues at most one register write
// per cycle. It also answers forwarding queries against writes that are
// still pending.
module regfile_writeback_queue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         AluValid,
    input  logic [ADDR_W-1:0]            AluRD,
    input  logic [DATA_W-1:0]            AluData,
    output logic                         AluReady,
    input  logic                         MemValid,
    input  logic [ADDR_W-1:0]            MemRD,
    input  logic [DATA_W-1:0]            MemData,
    output logic                         MemReady,
    output logic [ADDR_W-1:0]            RD,
    output logic [DATA_W-1:0]            WriteData,
    output logic                         RegWrite,
    input  logic [ADDR_W-1:0]            LookupRS,
    input  logic [ADDR_W-1:0]            LookupRT,
    output logic                         FwdRSHit,
    output logic [DATA_W-1:0]            FwdRSData,
    output logic                         FwdRTHit,
    output logic [DATA_W-1:0]            FwdRTData,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              mem_take;
    logic              alu_take;
    logic              enq;
    logic              deq;
    logic [ADDR_W-1:0] enq_rd;
    logic [DATA_W-1:0] enq_data;

    // Status flags and the accept decision; a load request always beats an ALU request
    always_comb begin
        Full     = (Count == CNT_W'(DEPTH));
        Empty    = (Count == '0);
        MemReady = !Full;
        AluReady = !Full && !MemValid;
        mem_take = MemValid && MemReady;
        alu_take = AluValid && AluReady;
        enq      = mem_take || alu_take;
        deq      = !Empty;
        enq_rd   = mem_take ? MemRD : AluRD;
        enq_data = mem_take ? MemData : AluData;
    end

    // FIFO storage; slots are qualified by Count, so they are never reset
    always_ff @(posedge Clock) begin
        if (enq) begin
            ent_rd[wr_ptr]   <= enq_rd;
            ent_data[wr_ptr] <= enq_data;
        end
    end

    // Pointers and occupancy; a push and a pop on the same edge leave Count unchanged
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   Count <= Count + CNT_W'(1);
                2'b01:   Count <= Count - CNT_W'(1);
                default: Count <= Count;
            endcase
        end
    end

    // Output stage: the head entry moves to the register-file write port; address and data hold while idle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= deq;
            if (deq) begin
                RD        <= ent_rd[rd_ptr];
                WriteData <= ent_data[rd_ptr];
            end
        end
    end

    // Forwarding search: the output stage is oldest, then head to tail, so later matches override
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        FwdRSHit  = 1'b0;
        FwdRSData = '0;
        FwdRTHit  = 1'b0;
        FwdRTData = '0;
        if (RegWrite && (RD == LookupRS)) begin
            FwdRSHit  = 1'b1;
            FwdRSData = WriteData;
        end
        if (RegWrite && (RD == LookupRT)) begin
            FwdRTHit  = 1'b1;
            FwdRTData = WriteData;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < Count) begin
                if (ent_rd[idx] == LookupRS) begin
                    FwdRSHit  = 1'b1;
                    FwdRSData = ent_data[idx];
                end
                if (ent_rd[idx] == LookupRT) begin
                    FwdRTHit  = 1'b1;
                    FwdRTData = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue. A queue-based model of the pending
// writes, plus the write-port stage, supplies all expected values.
module tb_regfile_writeback_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } ent_t;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        AluValid = 1'b0, MemValid = 1'b0;
    logic [2:0]  AluRD = '0, MemRD = '0, LookupRS = '0, LookupRT = '0;
    logic [15:0] AluData = '0, MemData = '0;
    logic        AluReady, MemReady, RegWrite, FwdRSHit, FwdRTHit, Full, Empty;
    logic [2:0]  RD;
    logic [15:0] WriteData, FwdRSData, FwdRTData;
    logic [2:0]  Count;

    int n_checks = 0;
    int n_pass   = 0;

    ent_t        pend[$];
    logic        m_ow = 1'b0;
    logic [2:0]  m_rd = '0;
    logic [15:0] m_wd = '0;

    regfile_writeback_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .AluValid(AluValid), .AluRD(AluRD), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRD(MemRD), .MemData(MemData), .MemReady(MemReady),
        .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
        .LookupRS(LookupRS), .LookupRT(LookupRT),
        .FwdRSHit(FwdRSHit), .FwdRSData(FwdRSData),
        .FwdRTHit(FwdRTHit), .FwdRTData(FwdRTData),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    always #5 Clock = ~Clock;

    task automatic model_reset();
        pend.delete();
        m_ow = 1'b0;
        m_rd = '0;
        m_wd = '0;
    endtask

    // Advance the model by one edge using the current inputs, then step the DUT
    task automatic tick();
        bit   was_full;
        ent_t e;
        was_full = (pend.size() == DEPTH);
        if (pend.size() > 0) begin
            e    = pend.pop_front();
            m_ow = 1'b1;
            m_rd = e.rd;
            m_wd = e.data;
        end else begin
            m_ow = 1'b0;
        end
        if (!was_full) begin
            if (MemValid)      pend.push_back({MemRD, MemData});
            else if (AluValid) pend.push_back({AluRD, AluData});
        end
        @(posedge Clock);
        #1;
    endtask

    // Youngest pending write to address a, or no hit
    function automatic void ref_fwd(input logic [2:0] a, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = '0;
        if (m_ow && m_rd == a) begin hit = 1'b1; d = m_wd; end
        for (int i = 0; i < pend.size(); i++)
            if (pend[i].rd == a) begin hit = 1'b1; d = pend[i].data; end
    endfunction

    task automatic idle_inputs();
        AluValid = 1'b0;
        MemValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %b expected 0", RegWrite); else n_pass++;
        n_checks++; if (Count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", Count); else n_pass++;
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            LookupRS = 3'($urandom_range(0, 7));
            tick();
            n_checks++; if (RegWrite !== 1'b0) $display("FAIL idle_regwrite: cycle %0d got %b expected 0", i, RegWrite); else n_pass++;
            n_checks++; if (Count !== 3'd0 || Empty !== 1'b1) $display("FAIL idle_count: cycle %0d got count=%0d empty=%b expected 0/1", i, Count, Empty); else n_pass++;
            n_checks++; if (FwdRSHit !== 1'b0) $display("FAIL idle_fwd: cycle %0d got hit=%b expected 0", i, FwdRSHit); else n_pass++;
        end
    endtask

    task automatic test_single();
        AluValid = 1'b1; AluRD = 3'd3; AluData = 16'h1234;
        tick();
        idle_inputs();
        n_checks++; if (Count !== 3'd1 || RegWrite !== 1'b0) $display("FAIL single_e1: got count=%0d we=%b expected 1/0", Count, RegWrite); else n_pass++;
        tick();
        n_checks++; if (RegWrite !== 1'b1 || RD !== 3'd3 || WriteData !== 16'h1234) $display("FAIL single_e2: got we=%b rd=%0d wd=%h expected 1/3/1234", RegWrite, RD, WriteData); else n_pass++;
        tick();
        n_checks++; if (RegWrite !== 1'b0 || RD !== 3'd3) $display("FAIL single_e3: got we=%b rd=%0d expected 0/3", RegWrite, RD); else n_pass++;
    endtask

    task automatic test_priority();
        AluValid = 1'b1; AluRD = 3'd1; AluData = 16'hAAAA;
        MemValid = 1'b1; MemRD = 3'd2; MemData = 16'h5555;
        #1;
        n_checks++; if (MemReady !== 1'b1 || AluReady !== 1'b0) $display("FAIL prio_ready: got mem=%b alu=%b expected 1/0", MemReady, AluReady); else n_pass++;
        tick();
        MemValid = 1'b0;
        #1;
        n_checks++; if (AluReady !== 1'b1) $display("FAIL prio_alu_ready: got %b expected 1", AluReady); else n_pass++;
        tick();
        AluValid = 1'b0;
        n_checks++; if (RegWrite !== 1'b1 || RD !== 3'd2 || WriteData !== 16'h5555) $display("FAIL prio_first: got we=%b rd=%0d wd=%h expected 1/2/5555", RegWrite, RD, WriteData); else n_pass++;
        tick();
        n_checks++; if (RegWrite !== 1'b1 || RD !== 3'd1 || WriteData !== 16'hAAAA) $display("FAIL prio_second: got we=%b rd=%0d wd=%h expected 1/1/aaaa", RegWrite, RD, WriteData); else n_pass++;
        tick();
        n_checks++; if (RegWrite !== 1'b0) $display("FAIL prio_done: got we=%b expected 0", RegWrite); else n_pass++;
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 4; i++) begin
            MemValid = 1'b1; MemRD = 3'(i + 4); MemData = 16'($urandom);
            tick();
        end
        idle_inputs();
        n_checks++; if (Count !== 3'd1 || RegWrite !== 1'b1) $display("FAIL burst_pre: got count=%0d we=%b expected 1/1", Count, RegWrite); else n_pass++;
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (Count !== 3'd0 || RegWrite !== 1'b0 || Empty !== 1'b1) $display("FAIL burst_async: got count=%0d we=%b empty=%b expected 0/0/1", Count, RegWrite, Empty); else n_pass++;
        n_checks++; if (RD !== 3'd0 || WriteData !== 16'h0) $display("FAIL burst_async_port: got rd=%0d wd=%h expected 0/0", RD, WriteData); else n_pass++;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (RegWrite !== 1'b0 || Count !== 3'd0) $display("FAIL burst_after: cycle %0d got we=%b count=%0d expected 0/0", i, RegWrite, Count); else n_pass++;
        end
    endtask

    task automatic test_forward();
        LookupRS = 3'd5;
        AluValid = 1'b1; AluRD = 3'd5; AluData = 16'h0001;
        tick();
        AluData = 16'h0002;
        tick();
        idle_inputs();
        n_checks++; if (FwdRSHit !== 1'b1 || FwdRSData !== 16'h0002) $display("FAIL fwd_both: got hit=%b data=%h expected 1/0002", FwdRSHit, FwdRSData); else n_pass++;
        tick();
        n_checks++; if (RegWrite !== 1'b1 || WriteData !== 16'h0002 || FwdRSHit !== 1'b1 || FwdRSData !== 16'h0002) $display("FAIL fwd_one: got we=%b wd=%h hit=%b data=%h expected 1/0002/1/0002", RegWrite, WriteData, FwdRSHit, FwdRSData); else n_pass++;
        tick();
        n_checks++; if (FwdRSHit !== 1'b0 || FwdRSData !== 16'h0) $display("FAIL fwd_none: got hit=%b data=%h expected 0/0", FwdRSHit, FwdRSData); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 11; i++) begin
            MemValid = (i < 10);
            MemRD    = 3'(i % 8);
            MemData  = 16'($urandom);
            tick();
            n_checks++; if (Count > 3'd1) $display("FAIL b2b_count: cycle %0d got %0d expected <=1", i, Count); else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (RegWrite !== 1'b1 || RD !== 3'((i - 1) % 8) || WriteData !== m_wd)
                    $display("FAIL b2b_order: cycle %0d got we=%b rd=%0d wd=%h expected 1/%0d/%h", i, RegWrite, RD, WriteData, (i - 1) % 8, m_wd);
                else n_pass++;
            end
        end
        idle_inputs();
        tick();
        n_checks++; if (RegWrite !== 1'b0 || Empty !== 1'b1) $display("FAIL b2b_drain: got we=%b empty=%b expected 0/1", RegWrite, Empty); else n_pass++;
    endtask

    task automatic test_random();
        logic        eh_rs, eh_rt;
        logic [15:0] ed_rs, ed_rt;
        for (int i = 0; i < 400; i++) begin
            AluValid = 1'($urandom_range(0, 1));
            MemValid = ($urandom_range(0, 3) == 0);
            AluRD    = 3'($urandom_range(0, 7));
            MemRD    = 3'($urandom_range(0, 7));
            AluData  = 16'($urandom);
            MemData  = 16'($urandom);
            LookupRS = 3'($urandom_range(0, 7));
            LookupRT = 3'($urandom_range(0, 7));
            #1;
            ref_fwd(LookupRS, eh_rs, ed_rs);
            ref_fwd(LookupRT, eh_rt, ed_rt);
            n_checks++; if (MemReady !== (pend.size() != DEPTH) || AluReady !== (pend.size() != DEPTH && !MemValid)) $display("FAIL rnd_ready: cycle %0d got mem=%b alu=%b", i, MemReady, AluReady); else n_pass++;
            n_checks++; if (FwdRSHit !== eh_rs || FwdRSData !== ed_rs) $display("FAIL rnd_fwd_rs: cycle %0d got %b/%h expected %b/%h", i, FwdRSHit, FwdRSData, eh_rs, ed_rs); else n_pass++;
            n_checks++; if (FwdRTHit !== eh_rt || FwdRTData !== ed_rt) $display("FAIL rnd_fwd_rt: cycle %0d got %b/%h expected %b/%h", i, FwdRTHit, FwdRTData, eh_rt, ed_rt); else n_pass++;
            n_checks++; if (Count !== 3'(pend.size()) || Empty !== (pend.size() == 0) || Full !== (pend.size() == DEPTH)) $display("FAIL rnd_count: cycle %0d got %0d expected %0d", i, Count, pend.size()); else n_pass++;
            tick();
            n_checks++; if (RegWrite !== m_ow || RD !== m_rd || WriteData !== m_wd) $display("FAIL rnd_port: cycle %0d got %b/%0d/%h expected %b/%0d/%h", i, RegWrite, RD, WriteData, m_ow, m_rd, m_wd); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_reset_midburst();
        test_forward();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
